// File: rtl/rah_pkg.sv
//------------------------------------------------------------------------------
// Module   : rah_pkg
// Brief    : Shared RAH framing definitions (header fields, magic, FSM states).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rah_pkg;

  localparam int c_hdr_id_lsb    = 0;
  localparam int c_hdr_id_w      = 8;
  localparam int c_hdr_len_lsb   = 8;
  localparam int c_hdr_len_w     = 16;
  localparam int c_hdr_magic_lsb = 24;
  localparam int c_hdr_magic_w   = 8;

  localparam logic [7:0] c_hdr_magic_default = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } rah_state_e;

  function automatic logic [c_hdr_id_w-1:0] hdr_id(input logic [31:0] hdr);
    return hdr[c_hdr_id_lsb +: c_hdr_id_w];
  endfunction

  function automatic logic [c_hdr_len_w-1:0] hdr_len(input logic [31:0] hdr);
    return hdr[c_hdr_len_lsb +: c_hdr_len_w];
  endfunction

  function automatic logic [c_hdr_magic_w-1:0] hdr_magic(input logic [31:0] hdr);
    return hdr[c_hdr_magic_lsb +: c_hdr_magic_w];
  endfunction

  // Encoder side: pack a header word from its fields.
  function automatic logic [31:0] hdr_pack(input logic [7:0]  magic,
                                           input logic [15:0] len,
                                           input logic [7:0]  id);
    return {magic, len, id};
  endfunction

endpackage : rah_pkg

`default_nettype wire

// File: rtl/rah_decoder.sv
//------------------------------------------------------------------------------
// Module   : rah_decoder
// Brief    : Splits framed MIPI words into per-application payload lanes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rah_decoder
  import rah_pkg::*;
#(
  parameter int         DATA_WIDTH = 48,
  parameter int         TOTAL_APPS = 8,
  parameter logic [7:0] HDR_MAGIC  = c_hdr_magic_default
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mipi_valid,
  input  logic [DATA_WIDTH-1:0] mipi_data,
  input  logic                  mipi_vsync,
  input  logic [TOTAL_APPS-1:0] app_ready,
  output logic [TOTAL_APPS-1:0] app_valid,
  output logic [DATA_WIDTH-1:0] app_data,
  output logic                  frame_done,
  output logic                  err_bad_hdr,
  output logic                  err_short,
  output logic [TOTAL_APPS-1:0] err_drop
);

  rah_state_e              r_state;
  rah_state_e              w_state_nxt;
  rah_state_e              w_cur_state;
  logic [15:0]             r_count;
  logic [15:0]             w_count_nxt;
  logic [7:0]              r_app_id;
  logic [7:0]              w_app_id_nxt;
  logic                    r_vsync_d;
  logic                    w_vsync_rise;

  logic [7:0]              w_hdr_id;
  logic [15:0]             w_hdr_len;
  logic [7:0]              w_hdr_magic;
  logic                    w_hdr_ok;
  logic [TOTAL_APPS-1:0]   w_lane;
  logic                    w_lane_ready;

  logic [TOTAL_APPS-1:0]   w_valid_nxt;
  logic                    w_data_load;
  logic                    w_done_nxt;
  logic                    w_set_bad;
  logic                    w_set_short;
  logic [TOTAL_APPS-1:0]   w_set_drop;

  assign w_vsync_rise = mipi_vsync & ~r_vsync_d;
  assign w_hdr_id     = hdr_id(mipi_data[31:0]);
  assign w_hdr_len    = hdr_len(mipi_data[31:0]);
  assign w_hdr_magic  = hdr_magic(mipi_data[31:0]);
  assign w_hdr_ok     = (w_hdr_magic == HDR_MAGIC) &&
                        ({24'd0, w_hdr_id} < 32'(TOTAL_APPS));
  assign w_lane       = TOTAL_APPS'(1) << r_app_id;
  assign w_lane_ready = |(app_ready & w_lane);

  // A vsync edge aborts first, so a word in the same cycle sees IDLE.
  assign w_cur_state  = w_vsync_rise ? ST_IDLE : r_state;

  always_comb begin
    w_state_nxt  = w_cur_state;
    w_count_nxt  = w_vsync_rise ? 16'd0 : r_count;
    w_app_id_nxt = r_app_id;
    w_valid_nxt  = '0;
    w_data_load  = 1'b0;
    w_done_nxt   = 1'b0;
    w_set_bad    = 1'b0;
    w_set_short  = w_vsync_rise && (r_state == ST_PAYLOAD) && (r_count != 16'd0);
    w_set_drop   = '0;

    case (w_cur_state)
      ST_IDLE: begin
        if (mipi_valid) begin
          if (!w_hdr_ok) begin
            w_set_bad   = 1'b1;
            w_state_nxt = ST_DISCARD;
          end else if (w_hdr_len == 16'd0) begin
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = ST_PAYLOAD;
            w_count_nxt  = w_hdr_len;
            w_app_id_nxt = w_hdr_id;
          end
        end
      end

      ST_PAYLOAD: begin
        if (mipi_valid) begin
          w_count_nxt = (r_count == 16'd0) ? 16'd0 : r_count - 16'd1;
          if (w_lane_ready) begin
            w_valid_nxt = w_lane;
            w_data_load = 1'b1;
          end else begin
            w_set_drop  = w_lane;
          end
          if (r_count <= 16'd1) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end

      ST_DISCARD: begin
        w_state_nxt = ST_DISCARD;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= 16'd0;
      r_app_id    <= 8'd0;
      r_vsync_d   <= 1'b0;
      app_valid   <= '0;
      app_data    <= '0;
      frame_done  <= 1'b0;
      err_bad_hdr <= 1'b0;
      err_short   <= 1'b0;
      err_drop    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_app_id    <= w_app_id_nxt;
      r_vsync_d   <= mipi_vsync;
      app_valid   <= w_valid_nxt;
      if (w_data_load) begin
        app_data  <= mipi_data;
      end
      frame_done  <= w_done_nxt;
      err_bad_hdr <= err_bad_hdr | w_set_bad;
      err_short   <= err_short | w_set_short;
      err_drop    <= err_drop | w_set_drop;
    end
  end

endmodule : rah_decoder

`default_nettype wire

// File: tb/tb_rah_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_rah_decoder
// Brief    : Directed self-checking bench for rah_decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rah_decoder;

  localparam int DW = 48;
  localparam int NA = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mipi_valid;
  logic [DW-1:0] mipi_data;
  logic          mipi_vsync;
  logic [NA-1:0] app_ready;
  logic [NA-1:0] app_valid;
  logic [DW-1:0] app_data;
  logic          frame_done;
  logic          err_bad_hdr;
  logic          err_short;
  logic [NA-1:0] err_drop;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rah_decoder #(
    .DATA_WIDTH (DW),
    .TOTAL_APPS (NA),
    .HDR_MAGIC  (8'hA5)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mipi_valid  (mipi_valid),
    .mipi_data   (mipi_data),
    .mipi_vsync  (mipi_vsync),
    .app_ready   (app_ready),
    .app_valid   (app_valid),
    .app_data    (app_data),
    .frame_done  (frame_done),
    .err_bad_hdr (err_bad_hdr),
    .err_short   (err_short),
    .err_drop    (err_drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [7:0] magic, input logic [15:0] len,
                                        input logic [7:0] id);
    return {16'hBEEF, magic, len, id};
  endfunction

  // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic vs,
                      input logic [NA-1:0] rdy);
    mipi_valid = v;
    mipi_data  = d;
    mipi_vsync = vs;
    app_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    mipi_valid = 1'b0;
    mipi_data  = '0;
    mipi_vsync = 1'b0;
    app_ready  = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    rst_n      = 1'b0;
    mipi_valid = 1'b0;
    mipi_data  = 48'hFFFF_FFFF_FFFF;
    mipi_vsync = 1'b0;
    app_ready  = '1;
    #3;
    check("rst_app_valid", 64'(app_valid), 64'h0);
    check("rst_app_data",  64'(app_data),  64'h0);
    check("rst_frame_done", 64'(frame_done), 64'h0);
    check("rst_errs", 64'({err_bad_hdr, err_short, err_drop}), 64'h0);
    do_reset();

    // Basic frame: id 2, three words, with an idle gap
    step(1'b1, hdr(8'hA5, 16'd3, 8'd2), 1'b0, 8'hFF);
    check("b_hdr_valid", 64'(app_valid), 64'h0);
    step(1'b1, 48'h1111_2222_3333, 1'b0, 8'hFF);
    check("b_w1_valid", 64'(app_valid), 64'h4);
    check("b_w1_data",  64'(app_data),  64'h1111_2222_3333);
    check("b_w1_done",  64'(frame_done), 64'h0);
    step(1'b0, 48'h0, 1'b0, 8'hFF);
    check("b_gap_valid", 64'(app_valid), 64'h0);
    step(1'b1, 48'h4444_5555_6666, 1'b0, 8'hFF);
    check("b_w2_valid", 64'(app_valid), 64'h4);
    check("b_w2_done",  64'(frame_done), 64'h0);
    step(1'b1, 48'h7777_8888_9999, 1'b0, 8'hFF);
    check("b_w3_valid", 64'(app_valid), 64'h4);
    check("b_w3_data",  64'(app_data),  64'h7777_8888_9999);
    check("b_w3_done",  64'(frame_done), 64'h1);
    step(1'b0, 48'h0, 1'b0, 8'hFF);
    check("b_after_done", 64'({app_valid, frame_done}), 64'h0);
    check("b_no_errs", 64'({err_bad_hdr, err_short, err_drop}), 64'h0);

    // Bad magic, discard until vsync edge; header in the edge cycle is decoded
    do_reset();
    step(1'b1, hdr(8'h5A, 16'd2, 8'd0), 1'b0, 8'hFF);
    check("m_bad_hdr", 64'(err_bad_hdr), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, hdr(8'hA5, 16'd1, 8'd1), 1'b0, 8'hFF);
      check("m_discard_valid", 64'({app_valid, frame_done}), 64'h0);
    end
    step(1'b1, hdr(8'hA5, 16'd1, 8'd3), 1'b1, 8'hFF);
    check("m_vs_hdr_valid", 64'(app_valid), 64'h0);
    step(1'b1, 48'hABCD_0000_1234, 1'b1, 8'hFF);
    check("m_recov_valid", 64'(app_valid), 64'h8);
    check("m_recov_data",  64'(app_data),  64'hABCD_0000_1234);
    check("m_recov_done",  64'(frame_done), 64'h1);
    check("m_short_clear", 64'(err_short), 64'h0);

    // Short frame: LEN 5, vsync edge after two words
    do_reset();
    step(1'b1, hdr(8'hA5, 16'd5, 8'd4), 1'b0, 8'hFF);
    step(1'b1, 48'h0000_0000_0001, 1'b0, 8'hFF);
    check("s_w1_valid", 64'(app_valid), 64'h10);
    step(1'b1, 48'h0000_0000_0002, 1'b0, 8'hFF);
    check("s_w2_valid", 64'(app_valid), 64'h10);
    step(1'b1, hdr(8'hA5, 16'd1, 8'd5), 1'b1, 8'hFF);
    check("s_err_short", 64'(err_short), 64'h1);
    check("s_edge_out", 64'({app_valid, frame_done}), 64'h0);
    check("s_no_bad", 64'(err_bad_hdr), 64'h0);
    step(1'b1, 48'h0000_0000_0055, 1'b1, 8'hFF);
    check("s_new_valid", 64'(app_valid), 64'h20);
    check("s_new_done",  64'(frame_done), 64'h1);

    // Backpressure drop on word 2 of 4, id 1
    do_reset();
    step(1'b1, hdr(8'hA5, 16'd4, 8'd1), 1'b0, 8'hFF);
    step(1'b1, 48'h0000_0000_00A1, 1'b0, 8'hFF);
    check("d_w1_valid", 64'(app_valid), 64'h2);
    step(1'b1, 48'h0000_0000_00A2, 1'b0, 8'hFD);
    check("d_w2_valid", 64'(app_valid), 64'h0);
    check("d_w2_drop",  64'(err_drop),  64'h2);
    check("d_w2_data",  64'(app_data),  64'h0000_0000_00A1);
    step(1'b1, 48'h0000_0000_00A3, 1'b0, 8'hFF);
    check("d_w3_valid", 64'(app_valid), 64'h2);
    check("d_w3_done",  64'(frame_done), 64'h0);
    step(1'b1, 48'h0000_0000_00A4, 1'b0, 8'hFF);
    check("d_w4_valid", 64'(app_valid), 64'h2);
    check("d_w4_done",  64'(frame_done), 64'h1);
    check("d_drop_sticky", 64'(err_drop), 64'h2);

    // LEN 0 header, then out-of-range id 9
    do_reset();
    step(1'b1, hdr(8'hA5, 16'd0, 8'd0), 1'b0, 8'hFF);
    check("z_done", 64'(frame_done), 64'h1);
    check("z_valid", 64'(app_valid), 64'h0);
    step(1'b1, hdr(8'hA5, 16'd2, 8'd9), 1'b0, 8'hFF);
    check("z_done_clear", 64'(frame_done), 64'h0);
    check("z_bad_id", 64'(err_bad_hdr), 64'h1);
    step(1'b1, 48'h0000_0000_0777, 1'b0, 8'hFF);
    check("z_discard", 64'(app_valid), 64'h0);

    // Asynchronous reset mid-payload
    do_reset();
    step(1'b1, hdr(8'hA5, 16'd3, 8'd0), 1'b0, 8'hFF);
    step(1'b1, 48'h0000_0000_0C01, 1'b0, 8'hFE);
    check("r_drop", 64'(err_drop), 64'h1);
    step(1'b1, 48'h0000_0000_0C02, 1'b0, 8'hFF);
    check("r_w2_valid", 64'(app_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_async_valid", 64'(app_valid), 64'h0);
    check("r_async_data",  64'(app_data),  64'h0);
    check("r_async_errs",  64'({err_bad_hdr, err_short, err_drop}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, hdr(8'hA5, 16'd1, 8'd7), 1'b0, 8'hFF);
    check("r_hdr_after", 64'(app_valid), 64'h0);
    check("r_no_bad", 64'(err_bad_hdr), 64'h0);
    step(1'b1, 48'h0000_0000_0C03, 1'b0, 8'hFF);
    check("r_id7_valid", 64'(app_valid), 64'h80);
    check("r_id7_done",  64'(frame_done), 64'h1);

    step(1'b0, 48'h0, 1'b0, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rah_decoder

`default_nettype wire
